cv32e40p_instr_obi_arbiter: RTL and testbench

//  Shares the core's single OBI instruction port between two requesters:

---
 rtl/cv32e40p_pkg.sv | 22 ++
 rtl/cv32e40p_instr_arb_idfifo.sv | 72 +++++++
 rtl/cv32e40p_instr_obi_arbiter_checker.sv | 20 ++
 rtl/cv32e40p_instr_obi_arbiter.sv | 110 +++++++++++
 tb/tb_cv32e40p_instr_obi_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the cv32e40p instruction-port arbiter slice.
// Holds the port count, the requester-id type and the round-robin pick helper.
package cv32e40p_pkg;

   localparam int INSTR_ARB_PORTS = 2;

   typedef logic [0:0] instr_arb_id_t;

   // Round-robin choice between two requesters; on a tie the port that did not win last goes.
   function automatic instr_arb_id_t instr_arb_rr_pick(input logic [1:0] req, input instr_arb_id_t last);
      instr_arb_id_t pick;
      if (req == 2'b11) begin
         pick = ~last;
      end else if (req[1]) begin
         pick = 1'b1;
      end else begin
         pick = 1'b0;
      end
      return pick;
   endfunction

endpackage

// File: rtl/cv32e40p_instr_arb_idfifo.sv
// In-order FIFO of requester ids, one entry per granted but not yet answered transaction.
// A push and a pop in the same cycle are both honoured, including when the FIFO is full.
module cv32e40p_instr_arb_idfifo #(
   parameter int DEPTH = 2,
   parameter int ID_W  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [ID_W-1:0] data_i,
   output logic [ID_W-1:0] data_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ID_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == PTR_W'(DEPTH - 1)) begin
         n = {PTR_W{1'b0}};
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == {CNT_W{1'b0}});
   assign data_o  = mem_q[rptr_q];

   // A pop frees the head slot first, so a push at full is accepted when paired with a pop.
   always_comb begin
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      wptr_d  = do_push ? ptr_next(wptr_q) : wptr_q;
      rptr_d  = do_pop ? ptr_next(rptr_q) : rptr_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= {PTR_W{1'b0}};
         rptr_q <= {PTR_W{1'b0}};
         cnt_q  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ID_W{1'b0}};
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (do_push) begin
            mem_q[wptr_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/cv32e40p_instr_obi_arbiter_checker.sv
// Protocol checks around the instruction-port arbiter: responses with nothing outstanding,
// and a requester withdrawing a request that is still waiting for grant.
module cv32e40p_instr_obi_arbiter_checker (
   input logic clk,
   input logic rst_n,
   input logic rvalid_i,
   input logic fifo_empty_i,
   input logic lock_i,
   input logic locked_req_i
);

   a_rvalid_with_empty_fifo : assert property (@(posedge clk) disable iff (!rst_n)
      !(rvalid_i && fifo_empty_i))
      else $error("instr_obi_arbiter: rvalid with no outstanding transaction");

   a_req_dropped_while_locked : assert property (@(posedge clk) disable iff (!rst_n)
      !(lock_i && !locked_req_i))
      else $error("instr_obi_arbiter: request withdrawn before grant");

endmodule

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Two-requester round-robin arbiter for the single OBI instruction port.
// Selection is locked while a request waits for grant; an id FIFO routes responses back.
module cv32e40p_instr_obi_arbiter
   import cv32e40p_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int ID_W  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_i,
   input  logic [1:0][31:0] addr_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       rvalid_o,
   output logic [31:0]      rdata_o,
   output logic [1:0]       err_o,
   output logic             instr_req_o,
   output logic [31:0]      instr_addr_o,
   input  logic             instr_gnt_i,
   input  logic             instr_rvalid_i,
   input  logic [31:0]      instr_rdata_i,
   input  logic             instr_err_i,
   output logic             busy_o
);

   instr_arb_id_t sel;
   instr_arb_id_t sel_q, sel_d;
   instr_arb_id_t rr_last_q, rr_last_d;
   logic          lock_q, lock_d;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          stall;
   logic [ID_W-1:0] head_id;

   // Bus request, address and grant pass straight through for the selected port.
   always_comb begin
      gnt_o    = 2'b00;
      rvalid_o = 2'b00;
      err_o    = 2'b00;
      if (lock_q) begin
         sel = sel_q;
      end else begin
         sel = instr_arb_rr_pick(req_i, rr_last_q);
      end
      stall        = fifo_full & ~instr_rvalid_i;
      instr_req_o  = req_i[sel] & ~stall;
      instr_addr_o = req_i[sel] ? addr_i[sel] : 32'h0000_0000;
      push         = instr_req_o & instr_gnt_i;
      gnt_o[sel]   = push;
      pop          = instr_rvalid_i & ~fifo_empty;
      rvalid_o[head_id] = pop;
      err_o[head_id]    = pop & instr_err_i;
      rdata_o      = pop ? instr_rdata_i : 32'h0000_0000;
      busy_o       = ~fifo_empty | (|req_i);
   end

   // Lock holds the selection from an ungranted request until its grant (or its withdrawal).
   always_comb begin
      if (lock_q) begin
         lock_d = req_i[sel_q] & ~push;
         sel_d  = sel_q;
      end else begin
         lock_d = instr_req_o & ~instr_gnt_i;
         sel_d  = sel;
      end
      if (push) begin
         rr_last_d = sel;
      end else begin
         rr_last_d = rr_last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_q    <= 1'b0;
         sel_q     <= 1'b0;
         rr_last_q <= 1'b1;
      end else begin
         lock_q    <= lock_d;
         sel_q     <= sel_d;
         rr_last_q <= rr_last_d;
      end
   end

   cv32e40p_instr_arb_idfifo #(
      .DEPTH (DEPTH),
      .ID_W  (ID_W)
   ) u_idfifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (instr_rvalid_i),
      .data_i  (sel),
      .data_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   cv32e40p_instr_obi_arbiter_checker u_checker (
      .clk          (clk),
      .rst_n        (rst_n),
      .rvalid_i     (instr_rvalid_i),
      .fifo_empty_i (fifo_empty),
      .lock_i       (lock_q),
      .locked_req_i (req_i[sel_q])
   );

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// Directed and randomized bench for the instruction-port arbiter against a queue-based model.
module tb_cv32e40p_instr_obi_arbiter;

   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_i;
   logic [1:0][31:0] addr_i;
   logic [1:0]       gnt_o, rvalid_o, err_o;
   logic [31:0]      rdata_o;
   logic             instr_req_o;
   logic [31:0]      instr_addr_o;
   logic             instr_gnt_i, instr_rvalid_i, instr_err_i;
   logic [31:0]      instr_rdata_i;
   logic             busy_o;

   always #5 clk = ~clk;

   cv32e40p_instr_obi_arbiter #(.DEPTH(DEPTH), .ID_W(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .instr_req_o(instr_req_o),
      .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .busy_o(busy_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: queue of outstanding requester ids, last winner, and a pending (waiting) port.
   logic        q[$];
   logic        m_last;
   logic        m_wait;
   logic        m_wport;
   logic        e_sel, e_req, e_busy;
   logic [1:0]  e_gnt, e_rv, e_err;
   logic [31:0] e_addr;

   logic [1:0]  cur_r;
   logic [31:0] cur_a [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_last  = 1'b1;
      m_wait  = 1'b0;
      m_wport = 1'b0;
   endtask

   task automatic apply(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                        input logic g, input logic rv, input logic er, input logic [31:0] rd);
      req_i = r; addr_i[0] = a0; addr_i[1] = a1;
      instr_gnt_i = g; instr_rvalid_i = rv; instr_err_i = er; instr_rdata_i = rd;
      #1;
      if (m_wait)            e_sel = m_wport;
      else if (r == 2'b11)   e_sel = ~m_last;
      else                   e_sel = r[1];
      e_req  = r[e_sel] && !((q.size() == DEPTH) && !rv);
      e_gnt  = (e_req && g) ? (e_sel ? 2'b10 : 2'b01) : 2'b00;
      e_rv   = (rv && q.size() > 0) ? (q[0] ? 2'b10 : 2'b01) : 2'b00;
      e_err  = er ? e_rv : 2'b00;
      e_busy = (q.size() > 0) || (r != 2'b00);
      e_addr = e_sel ? a1 : a0;
      chk("instr_req", {31'd0, instr_req_o}, {31'd0, e_req});
      if (e_req) chk("instr_addr", instr_addr_o, e_addr);
      chk("gnt", {30'd0, gnt_o}, {30'd0, e_gnt});
      chk("rvalid", {30'd0, rvalid_o}, {30'd0, e_rv});
      chk("err", {30'd0, err_o}, {30'd0, e_err});
      chk("busy", {31'd0, busy_o}, {31'd0, e_busy});
      if (e_rv != 2'b00) chk("rdata", rdata_o, rd);
   endtask

   task automatic tick();
      if (e_rv != 2'b00) void'(q.pop_front());
      if (e_gnt != 2'b00) begin
         q.push_back(e_sel);
         m_last = e_sel;
      end
      if (e_req && e_gnt == 2'b00) begin
         m_wait = 1'b1; m_wport = e_sel;
      end else if (!(m_wait && e_gnt == 2'b00 && req_i[m_wport])) begin
         m_wait = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_i = 2'b00; addr_i = '0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
      instr_err_i = 1'b0; instr_rdata_i = 32'h0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      model_reset();
      do_reset();
      // Reset state
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst_instr_req", {31'd0, instr_req_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      tick();

      // Test 1: port 0 alone
      apply(2'b01, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("t1_gnt", {30'd0, gnt_o}, 32'd1);
      tick();
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      chk("t1_rvalid", {30'd0, rvalid_o}, 32'd1);
      chk("t1_rdata", rdata_o, 32'hDEAD_BEEF);
      tick();

      // Test 2: both ports continuously, alternating grants
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(2'b11, 32'h200 + 32'(i), 32'h300 + 32'(i), 1'b1, (i > 0), 1'b0, 32'(i));
         chk("t2_gnt", {30'd0, gnt_o}, (i % 2 == 1) ? 32'd2 : 32'd1);
         if (i > 0) chk("t2_rvalid", {30'd0, rvalid_o}, (i % 2 == 1) ? 32'd1 : 32'd2);
         tick();
      end
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4);
      chk("t2_rvalid_last", {30'd0, rvalid_o}, 32'd2);
      tick();

      // Test 3: port 1 waits for grant; address and selection stay locked
      for (int i = 0; i < 3; i++) begin
         apply(2'b10, 32'h0, 32'h1A11_0800, 1'b0, 1'b0, 1'b0, 32'h0);
         chk("t3_addr_wait", instr_addr_o, 32'h1A11_0800);
         tick();
      end
      apply(2'b11, 32'h0000_0100, 32'h1A11_0800, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("t3_addr_locked", instr_addr_o, 32'h1A11_0800);
      tick();
      apply(2'b11, 32'h0000_0100, 32'h1A11_0800, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("t3_gnt_p1", {30'd0, gnt_o}, 32'd2);
      tick();
      apply(2'b01, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("t3_gnt_p0", {30'd0, gnt_o}, 32'd1);
      chk("t3_addr_p0", instr_addr_o, 32'h0000_0100);
      tick();
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11);
      tick();
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h22);
      tick();

      // Test 4: full FIFO stalls; rvalid + request at full lets the next grant through
      do_reset();
      apply(2'b01, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      apply(2'b10, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      apply(2'b01, 32'h30, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("t4_stall_req", {31'd0, instr_req_o}, 32'd0);
      chk("t4_stall_gnt", {30'd0, gnt_o}, 32'd0);
      tick();
      apply(2'b01, 32'h30, 32'h0, 1'b1, 1'b1, 1'b0, 32'h44);
      chk("t4_pass_req", {31'd0, instr_req_o}, 32'd1);
      chk("t4_pass_gnt", {30'd0, gnt_o}, 32'd1);
      chk("t4_pass_rvalid", {30'd0, rvalid_o}, 32'd1);
      tick();
      apply(2'b10, 32'h0, 32'h50, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("t4_still_full", {31'd0, instr_req_o}, 32'd0);
      tick();
      apply(2'b10, 32'h0, 32'h50, 1'b1, 1'b1, 1'b0, 32'h55);
      chk("t4_rvalid_p1", {30'd0, rvalid_o}, 32'd2);
      tick();
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h66);
      chk("t4_rvalid_p0", {30'd0, rvalid_o}, 32'd1);
      tick();
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h77);
      tick();

      // Test 5: bus error on a port-1 response
      apply(2'b10, 32'h0, 32'h60, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      apply(2'b01, 32'h70, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1234);
      chk("t5_rvalid", {30'd0, rvalid_o}, 32'd2);
      chk("t5_err", {30'd0, err_o}, 32'd2);
      tick();
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5678);
      chk("t5_p0_rvalid", {30'd0, rvalid_o}, 32'd1);
      chk("t5_p0_err", {30'd0, err_o}, 32'd0);
      tick();

      // Test 6: reset with two outstanding
      apply(2'b01, 32'h80, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      apply(2'b10, 32'h0, 32'h90, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      do_reset();
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("t6_busy", {31'd0, busy_o}, 32'd0);
      chk("t6_outputs", {gnt_o, rvalid_o, err_o, instr_req_o} , 32'd0);
      tick();
      apply(2'b01, 32'hA0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("t6_gnt", {30'd0, gnt_o}, 32'd1);
      tick();
      apply(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE);
      chk("t6_rvalid", {30'd0, rvalid_o}, 32'd1);
      tick();

      // Randomized traffic; requesters hold request and address until granted
      cur_r = 2'b00; cur_a[0] = 32'h0; cur_a[1] = 32'h0;
      for (int c = 0; c < 400; c++) begin
         apply(cur_r, cur_a[0], cur_a[1], 1'($urandom_range(0, 3) != 0),
               (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
               1'($urandom_range(0, 1)), $urandom);
         tick();
         for (int p = 0; p < 2; p++) begin
            if (!(cur_r[p] && !e_gnt[p])) begin
               cur_r[p] = 1'($urandom_range(0, 1));
               cur_a[p] = $urandom;
            end
         end
      end
      for (int k = 0; k < 60 && (cur_r != 2'b00 || q.size() != 0); k++) begin
         apply(cur_r, cur_a[0], cur_a[1], 1'b1, (q.size() > 0), 1'b0, $urandom);
         tick();
         for (int p = 0; p < 2; p++) begin
            if (!(cur_r[p] && !e_gnt[p])) cur_r[p] = 1'b0;
         end
      end
      chk("drain_done", {30'd0, (cur_r != 2'b00), (q.size() != 0)}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
